// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// PC source, writeback select and trap cause.
package rv_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_IMEM_TO = 2'b10,
    TC_DMEM_TO = 2'b11
  } trap_cause_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Sequencer <-> datapath/memory handshake bundle. Perf counters appear only
// when RV_CTRL_PERF_EN is defined.
interface rv_multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        imem_ack;
  logic        dmem_ack;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef RV_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  modport master (
    input  opcode, imem_ack, dmem_ack, branch_taken,
    output imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, reg_we,
           wb_sel, state, trap, trap_cause
`ifdef RV_CTRL_PERF_EN
    , output cycle_cnt, instret_cnt
`endif
  );

  modport slave (
    output opcode, imem_ack, dmem_ack, branch_taken,
    input  imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, reg_we,
           wb_sel, state, trap, trap_cause
`ifdef RV_CTRL_PERF_EN
    , input cycle_cnt, instret_cnt
`endif
  );
endinterface

// File: rtl/rv_req_timer.sv
// Wait counter shared by the imem and dmem requests; flags a timeout when the
// count reaches LIMIT with the request still unacknowledged.
module rv_req_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_req,
  input  logic i_ack,
  output logic o_timeout
);

  logic [7:0] r_cnt;
  logic       w_waiting;

  assign w_waiting = i_req && !i_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (w_waiting && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_timeout = w_waiting && (r_cnt == LIMIT);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB timing and strobes.
// Optional perf counters are built when RV_CTRL_PERF_EN is defined.
//
// state  | meaning
// FETCH  | post-reset hold, then imem_req until imem_ack (ir_we on ack)
// DECODE | register read, opcode legality check
// EXEC   | ALU; branch/FENCE retire here with pc_we
// MEM    | dmem_req until dmem_ack; store retires on ack
// WB     | reg_we + pc_we for one cycle
// TRAP   | sticky fault, left only through rst_n
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  rv_multicycle_ctrl_if.master bus
);

  state_e      r_state, w_next_state;
  trap_cause_e r_trap_cause, w_next_cause;
  logic [7:0]  r_hold_cnt;
  logic        r_fetch_en;
  logic        w_imem_req, w_dmem_req, w_req_ack, w_timer_clr, w_timeout;
  logic        w_is_load, w_is_store;
  logic        w_ir_we, w_pc_we, w_reg_we;
  pc_src_e     w_pc_src;
  wb_sel_e     w_wb_sel;

  assign w_is_load   = (bus.opcode == OP_LOAD);
  assign w_is_store  = (bus.opcode == OP_STORE);
  assign w_imem_req  = (r_state == ST_FETCH) && r_fetch_en;
  assign w_dmem_req  = (r_state == ST_MEM);
  assign w_req_ack   = w_imem_req ? bus.imem_ack : bus.dmem_ack;
  assign w_timer_clr = (r_state != ST_FETCH) && (r_state != ST_MEM);

  rv_req_timer #(.LIMIT(8'(MEM_TIMEOUT))) u_req_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clr),
    .i_req     (w_imem_req || w_dmem_req),
    .i_ack     (w_req_ack),
    .o_timeout (w_timeout)
  );

  // r_fetch_en is registered so no request is visible while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
      r_fetch_en <= 1'b0;
    end else begin
      if (r_hold_cnt != 8'(RESET_PC_HOLD)) r_hold_cnt <= r_hold_cnt + 8'd1;
      r_fetch_en <= r_fetch_en || (r_hold_cnt == 8'(RESET_PC_HOLD));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FETCH;
      r_trap_cause <= TC_NONE;
    end else begin
      r_state      <= w_next_state;
      r_trap_cause <= w_next_cause;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_trap_cause;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_reg_we     = 1'b0;
    w_pc_src     = PC_PLUS4;
    w_wb_sel     = WB_ALU;
    case (r_state)
      ST_FETCH: begin
        if (w_imem_req && bus.imem_ack) begin
          w_ir_we      = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_timeout) begin
          w_next_state = ST_TRAP;
          w_next_cause = TC_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal_op(bus.opcode)) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_TRAP;
          w_next_cause = TC_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_next_state = ST_MEM;
        end else if (bus.opcode == OP_BRANCH) begin
          w_pc_we      = 1'b1;
          w_pc_src     = bus.branch_taken ? PC_IMM : PC_PLUS4;
          w_next_state = ST_FETCH;
        end else if (bus.opcode == OP_FENCE) begin
          w_pc_we      = 1'b1;
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          if (w_is_store) begin
            w_pc_we      = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WB;
          end
        end else if (w_timeout) begin
          w_next_state = ST_TRAP;
          w_next_cause = TC_DMEM_TO;
        end
      end
      ST_WB: begin
        w_reg_we     = 1'b1;
        w_pc_we      = 1'b1;
        w_next_state = ST_FETCH;
        if (w_is_load)                                       w_wb_sel = WB_MEM;
        else if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) w_wb_sel = WB_PC4;
        if (bus.opcode == OP_JAL)       w_pc_src = PC_IMM;
        else if (bus.opcode == OP_JALR) w_pc_src = PC_ALU;
      end
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.ir_we      = w_ir_we;
  assign bus.pc_we      = w_pc_we;
  assign bus.pc_src     = w_pc_src;
  assign bus.dmem_req   = w_dmem_req;
  assign bus.dmem_we    = w_dmem_req && w_is_store;
  assign bus.reg_we     = w_reg_we;
  assign bus.wb_sel     = w_wb_sel;
  assign bus.state      = r_state;
  assign bus.trap       = (r_state == ST_TRAP);
  assign bus.trap_cause = r_trap_cause;

`ifdef RV_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt, r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_pc_we) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: per-cycle vector table plus
// hand-written trap, timeout and asynchronous-reset sequences.
module tb_rv_multicycle_ctrl;

  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] FENCE = 7'b0001111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  rv_multicycle_ctrl_if bus();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .RESET_PC_HOLD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic        ia;
    logic        da;
    logic        bt;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {state, imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, reg_we, wb_sel, trap, trap_cause}
  function automatic logic [15:0] e(logic [2:0] st, logic ireq, logic irwe, logic pcwe,
                                    logic [1:0] pcs, logic dreq, logic dwe, logic rwe,
                                    logic [1:0] wbs, logic trp, logic [1:0] cs);
    return {st, ireq, irwe, pcwe, pcs, dreq, dwe, rwe, wbs, trp, cs};
  endfunction

  function automatic logic [15:0] f_wait();  return e(0,1,0,0,2'b00,0,0,0,2'b00,0,2'b00); endfunction
  function automatic logic [15:0] f_ack();   return e(0,1,1,0,2'b00,0,0,0,2'b00,0,2'b00); endfunction
  function automatic logic [15:0] f_dec();   return e(1,0,0,0,2'b00,0,0,0,2'b00,0,2'b00); endfunction
  function automatic logic [15:0] f_exn();   return e(2,0,0,0,2'b00,0,0,0,2'b00,0,2'b00); endfunction
  function automatic logic [15:0] f_exb(logic [1:0] pcs); return e(2,0,0,1,pcs,0,0,0,2'b00,0,2'b00); endfunction
  function automatic logic [15:0] f_mem(logic dwe, logic pcwe); return e(3,0,0,pcwe,2'b00,1,dwe,0,2'b00,0,2'b00); endfunction
  function automatic logic [15:0] f_wb(logic [1:0] pcs, logic [1:0] wbs); return e(4,0,0,1,pcs,0,0,1,wbs,0,2'b00); endfunction
  function automatic logic [15:0] f_trap(logic [1:0] cs); return e(7,0,0,0,2'b00,0,0,0,2'b00,1,cs); endfunction

  function automatic logic [15:0] actual();
    return {bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.dmem_req,
            bus.dmem_we, bus.reg_we, bus.wb_sel, bus.trap, bus.trap_cause};
  endfunction

  task automatic add(input string nm, input logic [6:0] op, input logic ia, input logic da,
                     input logic bt, input logic [15:0] exp);
    vec_t v;
    v.nm = nm; v.op = op; v.ia = ia; v.da = da; v.bt = bt; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] exp);
    logic [15:0] act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic ia, input logic da, input logic bt);
    bus.opcode = op; bus.imem_ack = ia; bus.dmem_ack = da; bus.branch_taken = bt;
  endtask

  // Called just after a rising edge: drive, check at the falling edge, step a cycle.
  task automatic cyc(input string nm, input logic [6:0] op, input logic ia, input logic da,
                     input logic bt, input logic [15:0] exp);
    drive(op, ia, da, bt);
    @(negedge clk);
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic release_hold();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("hold0", ADD, 1, 0, 0, 16'h0000);
    cyc("hold1", ADD, 1, 0, 0, 16'h0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(ADD, 0, 0, 0);
    @(negedge clk);
    #1 check("reset_vec", 16'h0000);
    release_hold();
  endtask

  initial begin
    // ADD: imem_ack after two wait cycles; stray acks outside requests ignored
    add("add_f0", ADD, 0, 0, 0, f_wait());
    add("add_f1", ADD, 0, 0, 0, f_wait());
    add("add_f2", ADD, 1, 0, 0, f_ack());
    add("add_d",  ADD, 1, 1, 0, f_dec());
    add("add_e",  ADD, 1, 1, 0, f_exn());
    add("add_wb", ADD, 0, 1, 0, f_wb(2'b00, 2'b00));
    // LW: dmem_ack after one wait cycle
    add("lw_f",   LW, 1, 0, 0, f_ack());
    add("lw_d",   LW, 0, 0, 0, f_dec());
    add("lw_e",   LW, 0, 0, 0, f_exn());
    add("lw_m0",  LW, 0, 0, 0, f_mem(0, 0));
    add("lw_m1",  LW, 0, 1, 0, f_mem(0, 0));
    add("lw_wb",  LW, 0, 0, 0, f_wb(2'b00, 2'b01));
    // SW: pc_we in the ack cycle, no WB
    add("sw_f",   SW, 1, 0, 0, f_ack());
    add("sw_d",   SW, 0, 0, 0, f_dec());
    add("sw_e",   SW, 0, 0, 0, f_exn());
    add("sw_m0",  SW, 0, 0, 0, f_mem(1, 0));
    add("sw_m1",  SW, 0, 1, 0, f_mem(1, 1));
    // BEQ taken / not taken
    add("beqt_f", BEQ, 1, 0, 1, f_ack());
    add("beqt_d", BEQ, 0, 0, 1, f_dec());
    add("beqt_e", BEQ, 0, 0, 1, f_exb(2'b01));
    add("beqn_f", BEQ, 1, 0, 0, f_ack());
    add("beqn_d", BEQ, 0, 0, 0, f_dec());
    add("beqn_e", BEQ, 0, 0, 0, f_exb(2'b00));
    // JALR, JAL, LUI, FENCE
    add("jalr_f", JALR, 1, 0, 0, f_ack());
    add("jalr_d", JALR, 0, 0, 0, f_dec());
    add("jalr_e", JALR, 0, 0, 0, f_exn());
    add("jalr_w", JALR, 0, 0, 0, f_wb(2'b10, 2'b10));
    add("jal_f",  JAL, 1, 0, 0, f_ack());
    add("jal_d",  JAL, 0, 0, 0, f_dec());
    add("jal_e",  JAL, 0, 0, 0, f_exn());
    add("jal_w",  JAL, 0, 0, 0, f_wb(2'b01, 2'b10));
    add("lui_f",  LUI, 1, 0, 0, f_ack());
    add("lui_d",  LUI, 0, 0, 0, f_dec());
    add("lui_e",  LUI, 0, 0, 0, f_exn());
    add("lui_w",  LUI, 0, 0, 0, f_wb(2'b00, 2'b00));
    add("fen_f",  FENCE, 1, 0, 0, f_ack());
    add("fen_d",  FENCE, 0, 0, 0, f_dec());
    add("fen_e",  FENCE, 0, 0, 0, f_exb(2'b00));
    add("next_f", ADD, 0, 0, 0, f_wait());

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("%s[%0d]", tbl[i].nm, i), tbl[i].op, tbl[i].ia, tbl[i].da, tbl[i].bt, tbl[i].exp);

    // Illegal opcode: trap after DECODE, sticky against acks
    do_reset();
    cyc("ill_f", BAD, 1, 0, 0, f_ack());
    cyc("ill_d", BAD, 0, 0, 0, f_dec());
    for (int i = 0; i < 3; i++)
      cyc($sformatf("ill_trap%0d", i), BAD, 1, 1, 1, f_trap(2'b01));

    // imem timeout at limit 4: five request cycles, then TRAP
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc($sformatf("ito_w%0d", i), ADD, 0, 0, 0, f_wait());
    cyc("ito_trap0", ADD, 1, 0, 0, f_trap(2'b10));
    cyc("ito_trap1", ADD, 1, 0, 0, f_trap(2'b10));

    // ack in the limit cycle wins over the timeout
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc($sformatf("lim_w%0d", i), ADD, 0, 0, 0, f_wait());
    cyc("lim_ack", ADD, 1, 0, 0, f_ack());
    cyc("lim_dec", ADD, 0, 0, 0, f_dec());

    // dmem timeout on a load
    do_reset();
    cyc("dto_f", LW, 1, 0, 0, f_ack());
    cyc("dto_d", LW, 0, 0, 0, f_dec());
    cyc("dto_e", LW, 0, 0, 0, f_exn());
    for (int i = 0; i < 5; i++)
      cyc($sformatf("dto_m%0d", i), LW, 0, 0, 0, f_mem(0, 0));
    cyc("dto_trap", LW, 0, 1, 0, f_trap(2'b11));

    // Asynchronous reset mid-MEM aborts the store's pc_we strobe
    do_reset();
    cyc("ar_f",  SW, 1, 0, 0, f_ack());
    cyc("ar_d",  SW, 0, 0, 0, f_dec());
    cyc("ar_e",  SW, 0, 0, 0, f_exn());
    cyc("ar_m0", SW, 0, 0, 0, f_mem(1, 0));
    drive(SW, 0, 1, 0);
    #2 check("ar_ack_pcwe", f_mem(1, 1));
    rst_n = 1'b0;
    #1 check("ar_async_zero", 16'h0000);
    drive(ADD, 0, 0, 0);
    release_hold();
    cyc("ar_restart", ADD, 0, 0, 0, f_wait());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
